// File: rtl/warp_issue_scheduler_pkg.sv
// Shared types and constants for the warp issue stage: execution-unit encoding,
// warp sizing and the dispatcher error codes reported through the sticky err vector.
package warp_issue_scheduler_pkg;

  localparam int unsigned KIANA_NUM_WARP = 8;
  localparam int unsigned KIANA_WIDBITS  = 3;

  localparam logic [31:0] KIANA_SP_ERR_DISPATCHER_BOTH_LSU_ALU_USED = 32'h0000_0008;
  localparam logic [31:0] KIANA_SP_ERR_DISPATCHER_INSTRUCTION_SELECTED_WITH_EXE_UNIT_NOT_READY =
    32'h0000_0010;

  typedef enum logic [1:0] {
    EXE_ALU = 2'd0,
    EXE_LSU = 2'd1,
    EXE_BRA = 2'd2
  } exe_unit_t;

  // A head with neither ALU nor LSU flag set belongs to the branch unit.
  function automatic exe_unit_t head_unit(input logic uses_alu, input logic uses_lsu);
    if (uses_alu) return EXE_ALU;
    else if (uses_lsu) return EXE_LSU;
    else return EXE_BRA;
  endfunction

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// Bundle between the instruction-buffer/execution-unit side (master) and the
// issue scheduler (slave).
interface warp_issue_scheduler_if
  import warp_issue_scheduler_pkg::*;
#(
  parameter int unsigned NUM_WARP = KIANA_NUM_WARP,
  parameter int unsigned WID_W    = KIANA_WIDBITS
);
  logic [NUM_WARP-1:0] warp_active;
  logic [NUM_WARP-1:0] ibuf_valid;
  logic [NUM_WARP-1:0] ibuf_uses_alu;
  logic [NUM_WARP-1:0] ibuf_uses_lsu;
  logic [NUM_WARP-1:0] sb_stall;
  logic                alu_ready;
  logic                lsu_ready;
  logic                bra_ready;
  logic [NUM_WARP-1:0] ibuf_pop;
  logic                issue_valid;
  logic [WID_W-1:0]    issue_wid;
  exe_unit_t           issue_unit;
  logic [31:0]         err;

  modport master (
    output warp_active, ibuf_valid, ibuf_uses_alu, ibuf_uses_lsu, sb_stall,
           alu_ready, lsu_ready, bra_ready,
    input  ibuf_pop, issue_valid, issue_wid, issue_unit, err
  );

  modport slave (
    input  warp_active, ibuf_valid, ibuf_uses_alu, ibuf_uses_lsu, sb_stall,
           alu_ready, lsu_ready, bra_ready,
    output ibuf_pop, issue_valid, issue_wid, issue_unit, err
  );
endinterface

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i
// (wrapping) wins. Holds no state; the caller owns the pointer.
module rr_arbiter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] grant_idx_o,
  output logic         any_grant_o
);

  int unsigned idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!any_grant_o && req_i[W'(idx)]) begin
        any_grant_o          = 1'b1;
        grant_o[W'(idx)]     = 1'b1;
        grant_idx_o          = W'(idx);
      end
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Per-SM warp issue stage: picks one eligible warp per cycle, pops its head and
// registers the issue. Optional greedy re-issue under KIANA_SCHED_GREEDY_EN.
module warp_issue_scheduler
  import warp_issue_scheduler_pkg::*;
#(
  parameter int unsigned NUM_WARP = KIANA_NUM_WARP,
  parameter int unsigned WID_W    = KIANA_WIDBITS
) (
  input logic                    clk,
  input logic                    rst_n,
  warp_issue_scheduler_if.slave  sif
);

  logic [NUM_WARP-1:0] unit_rdy;
  logic [NUM_WARP-1:0] conflict;
  logic [NUM_WARP-1:0] elig;
  logic [NUM_WARP-1:0] rr_grant;
  logic [NUM_WARP-1:0] pop_raw;
  logic [WID_W-1:0]    rr_idx;
  logic                rr_any;
  logic [WID_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic                keep;
  exe_unit_t           gnt_unit;
  logic                gnt_rdy;

  logic [WID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                issue_valid_q, issue_valid_d;
  logic [WID_W-1:0]    issue_wid_q, issue_wid_d;
  exe_unit_t           issue_unit_q, issue_unit_d;
  logic [31:0]         err_q, err_d;

  always_comb begin
    unit_rdy = '0;
    for (int unsigned w = 0; w < NUM_WARP; w++) begin
      unit_rdy[w] = sif.ibuf_uses_alu[w] ? sif.alu_ready :
                    (sif.ibuf_uses_lsu[w] ? sif.lsu_ready : sif.bra_ready);
    end
  end

  assign conflict = sif.warp_active & sif.ibuf_valid & sif.ibuf_uses_alu & sif.ibuf_uses_lsu;
  assign elig     = sif.warp_active & sif.ibuf_valid & ~sif.sb_stall &
                    ~(sif.ibuf_uses_alu & sif.ibuf_uses_lsu) & unit_rdy;

  rr_arbiter #(
    .N (NUM_WARP),
    .W (WID_W)
  ) u_rr_arbiter (
    .req_i       (elig),
    .ptr_i       (rr_ptr_q),
    .grant_o     (rr_grant),
    .grant_idx_o (rr_idx),
    .any_grant_o (rr_any)
  );

`ifdef KIANA_SCHED_GREEDY_EN
  logic [WID_W-1:0] last_wid_q;
  logic             last_vld_q;

  assign keep = last_vld_q & elig[last_wid_q];

  always_comb begin
    pop_raw = rr_grant;
    if (keep) begin
      pop_raw             = '0;
      pop_raw[last_wid_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wid_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_vld_q <= gnt_any;
      if (gnt_any) last_wid_q <= gnt_idx;
    end
  end
`else
  assign keep    = 1'b0;
  assign pop_raw = rr_grant;
`endif

  assign gnt_any = keep | rr_any;
  assign gnt_idx = keep ? last_wid_q_or_rr() : rr_idx;

  function automatic logic [WID_W-1:0] last_wid_q_or_rr();
`ifdef KIANA_SCHED_GREEDY_EN
    return last_wid_q;
`else
    return rr_idx;
`endif
  endfunction

  assign gnt_unit = head_unit(sif.ibuf_uses_alu[gnt_idx], sif.ibuf_uses_lsu[gnt_idx]);

  always_comb begin
    gnt_rdy = 1'b0;
    unique case (gnt_unit)
      EXE_ALU: gnt_rdy = sif.alu_ready;
      EXE_LSU: gnt_rdy = sif.lsu_ready;
      default: gnt_rdy = sif.bra_ready;
    endcase
  end

  // Pops are combinational, so they are masked directly by reset.
  assign sif.ibuf_pop = pop_raw & {NUM_WARP{rst_n}};

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    issue_valid_d = gnt_any;
    issue_wid_d   = issue_wid_q;
    issue_unit_d  = issue_unit_q;
    err_d         = err_q;
    if (gnt_any) begin
      issue_wid_d  = gnt_idx;
      issue_unit_d = gnt_unit;
      if (!keep) begin
        rr_ptr_d = (gnt_idx == WID_W'(NUM_WARP - 1)) ? '0 : gnt_idx + WID_W'(1);
      end
      if (!gnt_rdy) begin
        err_d = err_d | KIANA_SP_ERR_DISPATCHER_INSTRUCTION_SELECTED_WITH_EXE_UNIT_NOT_READY;
      end
    end
    if (|conflict) begin
      err_d = err_d | KIANA_SP_ERR_DISPATCHER_BOTH_LSU_ALU_USED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_wid_q   <= '0;
      issue_unit_q  <= EXE_ALU;
      err_q         <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_wid_q   <= issue_wid_d;
      issue_unit_q  <= issue_unit_d;
      err_q         <= err_d;
    end
  end

  assign sif.issue_valid = issue_valid_q;
  assign sif.issue_wid   = issue_wid_q;
  assign sif.issue_unit  = issue_unit_q;
  assign sif.err         = err_q;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Randomized and directed bench for warp_issue_scheduler against a distance-based
// reference model of warp selection, issue registers and sticky errors.
module tb_warp_issue_scheduler;
  import warp_issue_scheduler_pkg::*;

  localparam int N = 8;

  logic clk;
  logic rst_n;

  warp_issue_scheduler_if #(.NUM_WARP(N), .WID_W(3)) bus ();

  warp_issue_scheduler #(.NUM_WARP(N), .WID_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_ptr;
  bit          m_vld;
  int          m_wid;
  int          m_unit;
  logic [31:0] m_err;
  bit          m_last_vld;
  int          m_last_wid;

  function automatic void model_reset();
    m_ptr = 0; m_vld = 0; m_wid = 0; m_unit = 0; m_err = 0;
    m_last_vld = 0; m_last_wid = 0;
  endfunction

  function automatic int unit_of(int w);
    if (bus.ibuf_uses_alu[w]) return 0;
    if (bus.ibuf_uses_lsu[w]) return 1;
    return 2;
  endfunction

  function automatic bit eligible(int w);
    bit rdy;
    if (!(bus.warp_active[w] && bus.ibuf_valid[w])) return 0;
    if (bus.sb_stall[w]) return 0;
    if (bus.ibuf_uses_alu[w] && bus.ibuf_uses_lsu[w]) return 0;
    case (unit_of(w))
      0: rdy = bus.alu_ready;
      1: rdy = bus.lsu_ready;
      default: rdy = bus.bra_ready;
    endcase
    return rdy;
  endfunction

  // Winner is the eligible warp at the smallest forward distance from the pointer.
  function automatic int pick(output bit kept);
    int best, bestd;
    kept = 0;
`ifdef KIANA_SCHED_GREEDY_EN
    if (m_last_vld && eligible(m_last_wid)) begin
      kept = 1;
      return m_last_wid;
    end
`endif
    best = -1; bestd = N;
    for (int w = 0; w < N; w++) begin
      if (eligible(w) && ((w - m_ptr + N) % N) < bestd) begin
        bestd = (w - m_ptr + N) % N;
        best  = w;
      end
    end
    return best;
  endfunction

  task automatic drive(input logic [7:0] act, input logic [7:0] vld, input logic [7:0] alu,
                       input logic [7:0] lsu, input logic [7:0] stl,
                       input logic ar, input logic lr, input logic br);
    bus.warp_active   = act;
    bus.ibuf_valid    = vld;
    bus.ibuf_uses_alu = alu;
    bus.ibuf_uses_lsu = lsu;
    bus.sb_stall      = stl;
    bus.alu_ready     = ar;
    bus.lsu_ready     = lr;
    bus.bra_ready     = br;
  endtask

  // Called just after a rising edge with inputs driven; ends just after the next edge.
  task automatic cycle_check(input string tag);
    int          g;
    bit          kept;
    logic [31:0] exp_pop;
    #4;
    g = pick(kept);
    exp_pop = (g >= 0) ? (32'd1 << g) : 32'd0;
    check({tag, ".pop"}, 32'(bus.ibuf_pop), exp_pop);
    @(posedge clk);
    #1;
    for (int w = 0; w < N; w++) begin
      if (bus.warp_active[w] && bus.ibuf_valid[w] && bus.ibuf_uses_alu[w] && bus.ibuf_uses_lsu[w])
        m_err = m_err | 32'h08;
    end
    m_vld = (g >= 0);
    if (g >= 0) begin
      m_wid = g;
      m_unit = unit_of(g);
      if (!kept) m_ptr = (g + 1) % N;
      m_last_wid = g;
    end
    m_last_vld = (g >= 0);
    check({tag, ".valid"}, 32'(bus.issue_valid), 32'(m_vld));
    if (m_vld) begin
      check({tag, ".wid"}, 32'(bus.issue_wid), 32'(m_wid));
      check({tag, ".unit"}, 32'(bus.issue_unit), 32'(m_unit));
    end
    check({tag, ".err"}, bus.err, m_err);
  endtask

  initial begin
    logic [7:0] alu, lsu;
    model_reset();
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    #1;
    check("rst.pop", 32'(bus.ibuf_pop), 32'd0);
    check("rst.valid", 32'(bus.issue_valid), 32'd0);
    check("rst.wid", 32'(bus.issue_wid), 32'd0);
    check("rst.unit", 32'(bus.issue_unit), 32'(EXE_ALU));
    check("rst.err", bus.err, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All warps ALU-bound and eligible: strict rotation
    for (int i = 0; i < 10; i++) cycle_check("rr_all");

    // Warps 2 and 5, warp 5 stalled for three cycles
    for (int i = 0; i < 7; i++) begin
      drive(8'hFF, 8'h24, 8'h24, 8'h00, (i < 3) ? 8'h20 : 8'h00, 1'b1, 1'b1, 1'b1);
      cycle_check("stall25");
    end

    // Warp 3 LSU waits for lsu_ready while warp 4 ALU issues
    for (int i = 0; i < 6; i++) begin
      drive(8'hFF, 8'h18, 8'h10, 8'h08, 8'h00, 1'b1, (i >= 3), 1'b1);
      cycle_check("lsu_wait");
    end

    // Warp 1 with a conflicting head, then deactivated
    for (int i = 0; i < 4; i++) begin
      drive((i < 2) ? 8'h02 : 8'h00, 8'h02, 8'h02, 8'h02, 8'h00, 1'b1, 1'b1, 1'b1);
      cycle_check("conflict");
    end

    // Warp 6 branch with toggling bra_ready
    for (int i = 0; i < 8; i++) begin
      drive(8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, logic'(i % 2));
      cycle_check("bra_toggle");
    end

    // Reset mid-cycle while an issue is registered
    drive(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    cycle_check("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.valid", 32'(bus.issue_valid), 32'd0);
    check("midrst.err", bus.err, 32'd0);
    check("midrst.pop", 32'(bus.ibuf_pop), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle_check("post_rst");
    check("post_rst.first", 32'(m_wid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      alu = 8'($urandom);
      lsu = 8'($urandom) & ~alu;
      if ($urandom_range(0, 31) == 0) lsu = lsu | (alu & (8'd1 << $urandom_range(0, 7)));
      drive(8'($urandom) | 8'($urandom), 8'($urandom) | 8'($urandom), alu, lsu,
            8'($urandom) & 8'($urandom),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)));
      cycle_check("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/warp_issue_scheduler.md
# warp_issue_scheduler

Per-SM issue stage that picks one warp per cycle from the instruction buffer and dispatches its head instruction to the ALU, LSU or branch unit. It sits between the per-warp instruction buffer slots and the execution units. It arbitrates the `KIANA_NUM_WARP` warps fairly, honours execution-unit readiness and scoreboard stalls, and reports dispatcher errors using the shared `KIANA_SP_ERR_*` codes.

## Interface
Parameters:
- NUM_WARP, `KIANA_NUM_WARP` (8): number of warps arbitrated.
- WID_W, `KIANA_WIDBITS` (3): warp-id width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- warp_active  in  NUM_WARP  warp is launched and not finished.
- ibuf_valid  in  NUM_WARP  warp's instruction-buffer head is valid.
- ibuf_uses_alu  in  NUM_WARP  head instruction targets the ALU.
- ibuf_uses_lsu  in  NUM_WARP  head instruction targets the LSU. If neither this nor `ibuf_uses_alu` is set, the head targets the branch unit.
- sb_stall  in  NUM_WARP  scoreboard hazard on the head instruction.
- alu_ready, lsu_ready, bra_ready  in  1 each  unit accepts an issue presented in the next cycle.
- ibuf_pop  out  NUM_WARP  one-hot; dequeues the selected head in the same cycle.
- issue_valid  out  1  registered issue strobe.
- issue_wid  out  WID_W  registered warp id.
- issue_unit  out  2  registered `exe_unit_t`.
- err  out  32  sticky error vector made of OR-ed `KIANA_SP_ERR_*` bits.

## Operation
Eligibility of warp w:
- `elig[w] = warp_active & ibuf_valid & ~sb_stall & ~(uses_alu & uses_lsu) & unit_ready(w)`.
- unit_ready(w) is `alu_ready` if uses_alu, `lsu_ready` if uses_lsu, otherwise `bra_ready`.

Selection:
- Round-robin search starting at `rr_ptr`, wrapping from NUM_WARP-1 to 0.
- Lowest index wins relative to `rr_ptr`.
- At most one grant per cycle.

On a grant to warp g:
- `ibuf_pop[g]=1` combinationally.
- `rr_ptr <= (g+1) mod NUM_WARP`.
- Issue registers load g and its unit.
- On a cycle with no grant, `rr_ptr` holds and `issue_valid` is 0 in the next cycle.

Conflicting head (uses_alu & uses_lsu on an active, valid warp):
- The warp is never granted.
- `err |= KIANA_SP_ERR_DISPATCHER_BOTH_LSU_ALU_USED` (0x08).

Defensive check:
- If the registered issue targets a unit whose ready bit was low in the grant cycle, `err |= KIANA_SP_ERR_DISPATCHER_INSTRUCTION_SELECTED_WITH_EXE_UNIT_NOT_READY` (0x10).
- This bit must never set in correct operation.

`err` bits are sticky and are cleared only by reset.

## Timing
- Reset values: `issue_valid=0`, `issue_wid=0`, `issue_unit=EXE_ALU`, `err=0`, `rr_ptr=0`, `last_wid=0`, `last_vld=0`. `ibuf_pop` is 0 while `rst_n` is low.
- Latency: inputs sampled in cycle t produce `ibuf_pop` in cycle t and `issue_*` valid in cycle t+1.
- Throughput: one issue per cycle, back-to-back to the same unit allowed.
- No input is registered, so a ready or stall change takes effect in the same cycle.
- Reset asserted mid-cycle clears all state immediately. No pop is emitted while `rst_n` is low.
- A warp that goes inactive in the same cycle it would win is not eligible. Arbitration proceeds to the next eligible warp.
- All `elig` bits 0 → no pop, and `issue_valid=0` next cycle.

## Configuration
`KIANA_SCHED_GREEDY_EN`:
- Defined: greedy-then-round-robin. If `last_vld` is set and `elig[last_wid]` is high, warp `last_wid` is granted again and `rr_ptr` is unchanged. Otherwise the round-robin search applies. `last_wid`/`last_vld` are updated on every grant; `last_vld` clears on a no-grant cycle.
- Undefined: pure round-robin. The `last_*` registers are not instantiated.

## Structure
Package `common` additions:
- `typedef enum logic [1:0] {EXE_ALU, EXE_LSU, EXE_BRA} exe_unit_t`.
- Existing `KIANA_SP_ERR_*` codes reused.
- `KIANA_NUM_WARP`/`KIANA_WIDBITS` taken from `i_cache`.

Sub-module `rr_arbiter`:
- Parameter N.
- Inputs: req[N], ptr.
- Outputs: one-hot grant, grant index, any_grant.
- Purely combinational, rotate-and-priority-encode.
- The top holds all state.

## Test plan
- All 8 warps eligible and ALU-bound, alu_ready=1 for 10 cycles → issue_wid sequence 0,1,…,7,0,1 with issue_valid continuous from cycle 1.
- Only warps 2 and 5 valid, warp 5 with sb_stall=1 for 3 cycles → issues 2,2,2 and then alternates 5,2,5 after the stall clears (with the greedy macro defined: 2 repeats until its ibuf_valid drops).
- Warp 3 LSU-bound with lsu_ready=0, warp 4 ALU-bound → only warp 4 issues. Warp 3 issues the cycle after lsu_ready rises. err stays 0.
- Warp 1 with uses_alu=uses_lsu=1 → never popped, err=0x08 next cycle and still 0x08 after the warp deactivates.
- Reset pulled low while issue_valid=1 → issue_valid=0, err=0, ibuf_pop=0 immediately. After release, the first grant starts from warp 0.
- Branch head on warp 6 with bra_ready toggling 0/1 each cycle → issue only in bra_ready=1 cycles, issue_unit=EXE_BRA, err bit 0x10 never set.
